// File: rtl/param_step_counter.sv
// Generic up/down counter with configurable modulo limit, step size and wrap/saturate behaviour.
// Reports limit crossings with a one-cycle terminal-count pulse and a sticky overflow flag.
module param_step_counter #(
  parameter int              WIDTH     = 8,
  parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 1,
  parameter int              SATURATE  = 0,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_zero
);

  // One extra bit so the modulus itself (up to 2**WIDTH) and carries are representable.
  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] MAX_D = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_D = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] data_reg, data_next;
  logic             tc_reg, tc_next;
  logic             ovf_reg, ovf_next;

  logic [WIDTH:0] cur_w, step_w, sum_w, step_mod;
  logic [WIDTH:0] up_wrap_sum, up_wrap, down_wrap;
  logic           event_up, event_down;

  assign cur_w  = {1'b0, data_reg};
  assign step_w = {1'b0, step};
  assign sum_w  = cur_w + step_w;

  // Events are judged on the raw step; the wrapped result uses the step reduced into range.
  assign step_mod    = step_w % MOD_W;
  assign up_wrap_sum = cur_w + step_mod;
  assign up_wrap     = (up_wrap_sum >= MOD_W) ? (up_wrap_sum - MOD_W) : up_wrap_sum;
  assign down_wrap   = (step_mod <= cur_w) ? (cur_w - step_mod) : (cur_w + MOD_W - step_mod);

  assign event_up   = (sum_w > MAX_W);
  assign event_down = (step_w > cur_w);

  always_comb begin
    data_next = data_reg;
    tc_next   = 1'b0;
    ovf_next  = ovf_reg;
    if (clr) begin
      data_next = RST_D;
      ovf_next  = 1'b0;
    end else if (load) begin
      data_next = ({1'b0, load_val} > MAX_W) ? MAX_D : load_val;
    end else if (en) begin
      if (up) begin
        if (event_up) begin
          data_next = (SATURATE != 0) ? MAX_D : WIDTH'(up_wrap);
          tc_next   = 1'b1;
          ovf_next  = 1'b1;
        end else begin
          data_next = WIDTH'(sum_w);
        end
      end else begin
        if (event_down) begin
          data_next = (SATURATE != 0) ? '0 : WIDTH'(down_wrap);
          tc_next   = 1'b1;
          ovf_next  = 1'b1;
        end else begin
          data_next = data_reg - step;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= RST_D;
      tc_reg   <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      data_reg <= data_next;
      tc_reg   <= tc_next;
      ovf_reg  <= ovf_next;
    end
  end

  assign data_out = data_reg;
  assign tc       = tc_reg;
  assign ovf      = ovf_reg;
  assign at_max   = (data_reg == MAX_D);
  assign at_zero  = (data_reg == '0);

endmodule

// File: tb/tb_param_step_counter.sv
// Three counter variants (wrap 0..9, saturate 0..9 with nonzero reset value, full 8-bit wrap)
// share one stimulus stream; a table, hand sequences and random traffic check them.
module tb_param_step_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, load, clr;
  logic [7:0] step, load_val;
  logic [7:0] dout    [3];
  logic       tc_o    [3];
  logic       ovf_o   [3];
  logic       amax_o  [3];
  logic       azero_o [3];

  always #5 clk = ~clk;

  param_step_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(0), .RESET_VAL(0)) u_wrap9 (
    .clk(clk), .reset(reset), .en(en), .up(up), .step(step), .load(load),
    .load_val(load_val), .clr(clr), .data_out(dout[0]), .tc(tc_o[0]), .ovf(ovf_o[0]),
    .at_max(amax_o[0]), .at_zero(azero_o[0]));

  param_step_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1), .RESET_VAL(2)) u_sat9 (
    .clk(clk), .reset(reset), .en(en), .up(up), .step(step), .load(load),
    .load_val(load_val), .clr(clr), .data_out(dout[1]), .tc(tc_o[1]), .ovf(ovf_o[1]),
    .at_max(amax_o[1]), .at_zero(azero_o[1]));

  param_step_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(0), .RESET_VAL(0)) u_full (
    .clk(clk), .reset(reset), .en(en), .up(up), .step(step), .load(load),
    .load_val(load_val), .clr(clr), .data_out(dout[2]), .tc(tc_o[2]), .ovf(ovf_o[2]),
    .at_max(amax_o[2]), .at_zero(azero_o[2]));

  // Reference model: plain integer arithmetic on the counting rules.
  longint maxv [3] = '{9, 9, 255};
  int     satv [3] = '{0, 1, 0};
  longint rstv [3] = '{0, 2, 0};
  longint m_cnt [3];
  bit     m_tc  [3];
  bit     m_ovf [3];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit r, e, u; int s; bit l; int lv; bit c;
    int d; bit t; bit o;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(bit r, bit e, bit u, int s, bit l, int lv, bit c,
                              int d, bit t, bit o);
    vec_t v;
    v.r = r; v.e = e; v.u = u; v.s = s; v.l = l; v.lv = lv; v.c = c;
    v.d = d; v.t = t; v.o = o;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic void model_update();
    for (int k = 0; k < 3; k++) begin
      longint m = maxv[k] + 1;
      bit ev = 1'b0;
      if (reset || clr) begin
        m_cnt[k] = rstv[k];
        m_ovf[k] = 1'b0;
      end else if (load) begin
        m_cnt[k] = (longint'(load_val) > maxv[k]) ? maxv[k] : longint'(load_val);
      end else if (en) begin
        if (up) begin
          longint s = m_cnt[k] + longint'(step);
          if (s > maxv[k]) begin
            ev = 1'b1;
            m_cnt[k] = (satv[k] != 0) ? maxv[k] : (s % m);
          end else m_cnt[k] = s;
        end else begin
          if (longint'(step) > m_cnt[k]) begin
            ev = 1'b1;
            m_cnt[k] = (satv[k] != 0) ? 0 : (((m_cnt[k] - longint'(step)) % m) + m) % m;
          end else m_cnt[k] = m_cnt[k] - longint'(step);
        end
      end
      m_tc[k] = ev;
      if (ev) m_ovf[k] = 1'b1;
    end
  endfunction

  task automatic cycle(input bit r, input bit e, input bit u, input int s,
                       input bit l, input int lv, input bit c);
    reset = r; en = e; up = u; step = 8'(s); load = l; load_val = 8'(lv); clr = c;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model(input string tag, input int lo);
    for (int k = lo; k < 3; k++) begin
      check($sformatf("%s.u%0d.data", tag, k), dout[k], m_cnt[k]);
      check($sformatf("%s.u%0d.tc", tag, k), tc_o[k], m_tc[k]);
      check($sformatf("%s.u%0d.ovf", tag, k), ovf_o[k], m_ovf[k]);
      check($sformatf("%s.u%0d.at_max", tag, k), amax_o[k], m_cnt[k] == maxv[k]);
      check($sformatf("%s.u%0d.at_zero", tag, k), azero_o[k], m_cnt[k] == 0);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b0; step = '0; load = 1'b0; load_val = '0; clr = 1'b0;

    // Expected values for the wrap-at-9 instance.
    add(1,0,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0,0, 0,0,0);
    for (int i = 1; i <= 9; i++) add(0,1,1,1,0,0,0, i,0,0);
    add(0,1,1,1,0,0,0, 0,1,1);
    add(0,1,1,1,0,0,0, 1,0,1);
    add(0,1,1,1,0,0,0, 2,0,1);
    add(0,0,0,0,1,3,0, 3,0,1);
    add(0,1,0,5,0,0,0, 8,1,1);
    add(0,1,0,5,0,0,0, 3,0,1);
    add(0,1,1,1,1,5,1, 0,0,0);    // clr beats load and en
    add(0,0,0,0,1,5,0, 5,0,0);
    add(0,0,0,0,1,200,0, 9,0,0);  // out-of-range load clamps
    add(0,1,1,0,0,0,0, 9,0,0);    // zero step holds at the limit
    add(0,1,1,23,0,0,0, 2,1,1);   // step above MAX_VAL
    add(0,0,0,0,0,0,0, 2,0,1);
    add(0,0,0,0,1,6,0, 6,0,1);
    add(1,1,1,1,1,4,0, 0,0,0);    // reset beats load and en
    add(0,1,1,1,0,0,0, 1,0,0);

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].s, vecs[i].l, vecs[i].lv, vecs[i].c);
      $display("vec %0d: data=%0d tc=%0d ovf=%0d", i, dout[0], tc_o[0], ovf_o[0]);
      check($sformatf("vec%0d.data", i), dout[0], vecs[i].d);
      check($sformatf("vec%0d.tc", i), tc_o[0], vecs[i].t);
      check($sformatf("vec%0d.ovf", i), ovf_o[0], vecs[i].o);
      check($sformatf("vec%0d.at_max", i), amax_o[0], vecs[i].d == 9);
      check($sformatf("vec%0d.at_zero", i), azero_o[0], vecs[i].d == 0);
      check_model($sformatf("vec%0d", i), 1);
    end

    // Saturating instance: clamp high, repeated pulses at the limit, clamp low.
    cycle(0,0,0,0,1,7,0);
    $display("sat load: data=%0d", dout[1]);
    check("sat.load", dout[1], 7);
    cycle(0,1,1,4,0,0,0);
    $display("sat up4: data=%0d tc=%0d", dout[1], tc_o[1]);
    check("sat.up.data", dout[1], 9);
    check("sat.up.tc", tc_o[1], 1);
    for (int i = 0; i < 2; i++) begin
      cycle(0,1,1,4,0,0,0);
      $display("sat hold %0d: data=%0d tc=%0d", i, dout[1], tc_o[1]);
      check("sat.hold.data", dout[1], 9);
      check("sat.hold.tc", tc_o[1], 1);
    end
    cycle(0,1,0,20,0,0,0);
    $display("sat down20: data=%0d tc=%0d ovf=%0d", dout[1], tc_o[1], ovf_o[1]);
    check("sat.down.data", dout[1], 0);
    check("sat.down.tc", tc_o[1], 1);
    check("sat.down.ovf", ovf_o[1], 1);
    check_model("sat", 0);

    // Full 8-bit range wrap, then zero step.
    cycle(0,0,0,0,1,250,0);
    check("full.load", dout[2], 250);
    cycle(0,1,1,10,0,0,0);
    $display("full up10: data=%0d tc=%0d", dout[2], tc_o[2]);
    check("full.wrap.data", dout[2], 4);
    check("full.wrap.tc", tc_o[2], 1);
    cycle(0,1,1,0,0,0,0);
    $display("full step0: data=%0d tc=%0d", dout[2], tc_o[2]);
    check("full.hold.data", dout[2], 4);
    check("full.hold.tc", tc_o[2], 0);
    check_model("full", 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      int sel, s;
      sel = $urandom_range(0, 2);
      s = (sel == 0) ? $urandom_range(0, 3) : (sel == 1) ? $urandom_range(0, 15) : $urandom_range(0, 255);
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), s,
            $urandom_range(0, 7) == 0, $urandom_range(0, 255), $urandom_range(0, 29) == 0);
      $display("rnd %0d: data=%0d/%0d/%0d tc=%0d%0d%0d", i, dout[0], dout[1], dout[2],
               tc_o[0], tc_o[1], tc_o[2]);
      check_model($sformatf("rnd%0d", i), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_step_counter.md
Name: param_step_counter

Overview:
- Parametrised successor to the team's fixed 8-bit free-running counter.
- Provides configurable width, modulo limit, step size, up/down direction, wrap or saturate mode, synchronous load/clear, a terminal-count pulse and a sticky overflow flag.
- Used as the generic counter primitive by timers, address generators and test-pattern sources in the advanced-features suite.

Parameters:
- WIDTH, 8, counter and data width in bits (≥2).
- MAX_VAL, 2**WIDTH-1, highest legal count. Range is 0..MAX_VAL; must be ≤ 2**WIDTH-1.
- SATURATE, 0, 0 = wrap modulo (MAX_VAL+1); 1 = clamp at 0 / MAX_VAL.
- RESET_VAL, 0, count value after reset and after clr; must be ≤ MAX_VAL.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- step  input  WIDTH  step size per enabled cycle. 0 is legal and holds the count.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load.
- clr  input  1  synchronous return to RESET_VAL and clear of ovf.
- data_out  output  WIDTH  current count (registered).
- tc  output  1  one-cycle registered pulse on a wrap or saturation event.
- ovf  output  1  sticky flag, set on any wrap or saturation event.
- at_max  output  1  combinational: data_out == MAX_VAL.
- at_zero  output  1  combinational: data_out == 0.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high: the clock is named clk and the reset is named reset, sampled only on the rising clk edge.
  - On reset: data_out = RESET_VAL, tc = 0, ovf = 0.
- Priority per cycle: reset > clr > load > en. Only the highest active action takes effect.
- clr: data_out <= RESET_VAL; tc <= 0; ovf <= 0.
- load:
  - data_out <= min(load_val, MAX_VAL). An out-of-range load clamps to MAX_VAL.
  - tc <= 0; ovf unchanged.
- en, up = 1, arithmetic in WIDTH+1 bits:
  - Let sum = data_out + step.
  - If sum ≤ MAX_VAL: data_out <= sum, no event.
  - Otherwise, wrap mode: data_out <= (sum - (MAX_VAL+1)) mod (MAX_VAL+1). Saturate mode: data_out <= MAX_VAL.
  - An event (tc = 1, ovf set) occurs when sum > MAX_VAL.
  - In saturate mode, an event also occurs when data_out is already MAX_VAL and step > 0 (repeated pulses while held at the limit).
- en, up = 0:
  - If step ≤ data_out: data_out <= data_out - step, no event.
  - Otherwise, wrap mode: data_out <= data_out + (MAX_VAL+1) - step, reduced mod (MAX_VAL+1). Saturate mode: data_out <= 0.
  - Event as above when step > data_out.
- step > MAX_VAL is legal; the result is always reduced mod (MAX_VAL+1) in wrap mode.
- step = 0 with en: count holds, tc = 0, no event.
- Idle (no action): data_out holds; tc <= 0.
- tc timing: tc is high exactly for the cycle after the event edge, i.e. aligned with the updated data_out. Consecutive events give consecutive tc pulses.
- ovf: cleared only by reset or clr. A clr and an event in the same cycle resolve as clr (ovf = 0).
- Latency: every registered output reflects inputs sampled at the previous rising edge. at_max/at_zero follow data_out combinationally.
- Reset asserted mid-count overrides load/en in that cycle; counting resumes from RESET_VAL on the first cycle after reset deasserts.

Test Plan:
- Reset, wrap basics (WIDTH=8, MAX_VAL=9, SATURATE=0): reset 2 cycles, then en=1, up=1, step=1 for 12 cycles → data_out 1,2,…,9,0,1,2. tc high only on the cycle data_out shows 0. ovf = 1 thereafter; at_max high when data_out = 9.
- Step wrap down (same config): load_val=3, then en, up=0, step=5 → data_out 3→8 (3+10-5), tc = 1. Next cycle 8→3, tc = 0.
- Saturate (SATURATE=1, MAX_VAL=9): load 7, up, step=4 → 9, tc = 1. Hold en for 2 more cycles → stays 9, tc = 1 each cycle. Switch up=0, step=20 → 0, tc = 1.
- Priority: in one cycle assert clr, load (load_val=5) and en with ovf = 1 → data_out = RESET_VAL, ovf = 0. Next cycle load only → 5. Next cycle load_val=200 → 9 (clamped).
- Mid-operation reset: counting at 6, assert reset together with load and en → data_out = RESET_VAL, tc = 0, ovf = 0. Release reset with en held → RESET_VAL+step on the next edge.
- Full-range default (MAX_VAL=255): from 250, step=10 → 4, tc = 1. step=0 with en → holds at 4, tc = 0.
